// File: rtl/bench_sequencer.sv
// ============================================================================
// Module   : bench_sequencer
// Purpose  : Programmable trigger / data-pulse sequencer for the bench pattern
//            path. Trigger is aligned to a free-running ring-clock phase; a
//            single data_out pulse per shot launches at a configured
//            ring period and ring phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bench_sequencer #(
  parameter int RING_PERIOD  = 164,
  parameter int RING_HOLDOFF = 82,
  parameter int REP_W        = 21,
  parameter int OPW_W        = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [7:0]       burst_len,
  input  logic [REP_W-1:0] cfg_rep,
  input  logic [7:0]       cfg_trig_len,
  input  logic [7:0]       cfg_dout_delay,
  input  logic [7:0]       cfg_dout_offset,
  input  logic [OPW_W-1:0] cfg_op_width,
  output logic             trig,
  output logic             data_out,
  output logic             busy,
  output logic [7:0]       shot_count,
  output logic             done,
  output logic             cfg_err
);

  localparam int PH_W = $clog2(RING_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state;
  logic [PH_W-1:0]   ring_ph;
  logic              ring_edge;
  logic [REP_W-1:0]  per_ctr;
  logic [OPW_W-1:0]  op_ctr;

  // Configuration snapshot taken at an accepted start
  logic              mode_q;
  logic [7:0]        burst_len_q;
  logic [REP_W-1:0]  rep_q;
  logic [7:0]        trig_len_q;
  logic [7:0]        dout_delay_q;
  logic [7:0]        dout_offset_q;
  logic [OPW_W-1:0]  op_width_q;

  logic              cfg_bad;
  logic              launch;
  logic [REP_W-1:0]  per_next;
  logic [7:0]        shot_next;

  // Free-running ring phase; ring_edge marks the cycle after the holdoff phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_ph   <= '0;
      ring_edge <= 1'b0;
    end else begin
      ring_ph   <= (ring_ph == PH_W'(RING_PERIOD - 1)) ? '0 : ring_ph + 1'b1;
      ring_edge <= (ring_ph == PH_W'(RING_HOLDOFF));
    end
  end

  // Configuration sanity check applied to the live inputs when start arrives
  always_comb begin
    cfg_bad = 1'b0;
    if (cfg_trig_len == 8'd0)                    cfg_bad = 1'b1;
    if (REP_W'(cfg_trig_len) > cfg_rep)          cfg_bad = 1'b1;
    if (REP_W'(cfg_dout_delay) > cfg_rep)        cfg_bad = 1'b1;
    if (32'(cfg_dout_offset) >= RING_PERIOD)     cfg_bad = 1'b1;
    if (cfg_op_width == '0)                      cfg_bad = 1'b1;
    if (mode && (burst_len == 8'd0))             cfg_bad = 1'b1;
  end

  // Next-count helpers and the data_out launch point (ignored while pulse is high)
  always_comb begin
    per_next  = per_ctr + 1'b1;
    shot_next = (shot_count == 8'hFF) ? 8'hFF : shot_count + 8'd1;
    launch    = (state == S_RUN) && !data_out &&
                (per_ctr == REP_W'(dout_delay_q)) &&
                (32'(ring_ph) == 32'(dout_offset_q));
  end

  // Sequencer FSM with registered trig/data_out/busy/done/cfg_err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      per_ctr       <= '0;
      op_ctr        <= '0;
      trig          <= 1'b0;
      data_out      <= 1'b0;
      busy          <= 1'b0;
      shot_count    <= 8'd0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      mode_q        <= 1'b0;
      burst_len_q   <= 8'd0;
      rep_q         <= '0;
      trig_len_q    <= 8'd0;
      dout_delay_q  <= 8'd0;
      dout_offset_q <= 8'd0;
      op_width_q    <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        trig     <= 1'b0;
        data_out <= 1'b0;
        op_ctr   <= '0;
      end else begin
        // Pulse generator: high for exactly op_width_q clocks once launched
        if (data_out) begin
          if (op_ctr == OPW_W'(1)) begin
            data_out <= 1'b0;
            op_ctr   <= '0;
          end else begin
            op_ctr <= op_ctr - 1'b1;
          end
        end else if (launch) begin
          data_out <= 1'b1;
          op_ctr   <= op_width_q;
        end

        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                mode_q        <= mode;
                burst_len_q   <= burst_len;
                rep_q         <= cfg_rep;
                trig_len_q    <= cfg_trig_len;
                dout_delay_q  <= cfg_dout_delay;
                dout_offset_q <= cfg_dout_offset;
                op_width_q    <= cfg_op_width;
                shot_count    <= 8'd0;
                busy          <= 1'b1;
                state         <= S_ARM;
              end
            end
          end
          S_ARM: begin
            if (ring_edge) begin
              per_ctr <= '0;
              trig    <= 1'b1;
              state   <= S_RUN;
            end
          end
          S_RUN: begin
            if (ring_edge) begin
              if (per_ctr == rep_q) begin
                shot_count <= shot_next;
                if (!mode_q || (shot_next < burst_len_q)) begin
                  per_ctr <= '0;
                  trig    <= 1'b1;
                end else begin
                  trig  <= 1'b0;
                  state <= S_DRAIN;
                end
              end else begin
                per_ctr <= per_next;
                if (per_next == REP_W'(trig_len_q)) trig <= 1'b0;
              end
            end
          end
          S_DRAIN: begin
            if (!data_out) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bench_sequencer.sv
// ============================================================================
// Module   : tb_bench_sequencer
// Purpose  : Directed self-checking bench for bench_sequencer. Event times are
//            recorded relative to the first trigger of a sequence and compared
//            against hand-derived tables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bench_sequencer;

  localparam int K_TR = 0;  // trig rise
  localparam int K_TF = 1;  // trig fall
  localparam int K_DR = 2;  // data_out rise
  localparam int K_DF = 3;  // data_out fall
  localparam int K_DN = 4;  // done pulse
  localparam int K_BF = 5;  // busy fall
  localparam int K_ER = 6;  // cfg_err pulse

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  burst_len = 8'd0;
  logic [20:0] cfg_rep = 21'd0;
  logic [7:0]  cfg_trig_len = 8'd0;
  logic [7:0]  cfg_dout_delay = 8'd0;
  logic [7:0]  cfg_dout_offset = 8'd0;
  logic [9:0]  cfg_op_width = 10'd0;
  logic        trig, data_out, busy, done, cfg_err;
  logic [7:0]  shot_count;

  int cyc;
  int base;
  int n_checks = 0;
  int n_fail   = 0;
  int ev[$];

  bench_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .burst_len(burst_len), .cfg_rep(cfg_rep), .cfg_trig_len(cfg_trig_len),
    .cfg_dout_delay(cfg_dout_delay), .cfg_dout_offset(cfg_dout_offset),
    .cfg_op_width(cfg_op_width), .trig(trig), .data_out(data_out),
    .busy(busy), .shot_count(shot_count), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Clock count since reset release; sample k sees ring_ph == k % 164
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int evc(input int off, input int kind);
    return off * 8 + kind;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic align0();
    while ((cyc % 164) != 0) step();
  endtask

  task automatic set_cfg(input logic m, input logic [7:0] bl, input logic [20:0] rep,
                         input logic [7:0] tl, input logic [7:0] dd,
                         input logic [7:0] doff, input logic [9:0] opw);
    mode = m; burst_len = bl; cfg_rep = rep; cfg_trig_len = tl;
    cfg_dout_delay = dd; cfg_dout_offset = doff; cfg_op_width = opw;
  endtask

  // Runs n cycles recording output events (offset from base); optionally
  // pulses start with a different configuration at absolute cycle poke_cyc.
  task automatic watch(input int n, input int poke_cyc);
    logic pt, pd, pb;
    ev.delete();
    pt = trig; pd = data_out; pb = busy;
    for (int i = 0; i < n; i++) begin
      step();
      if (cyc == poke_cyc) begin
        set_cfg(1'b0, 8'd9, 21'd1, 8'd1, 8'd0, 8'd5, 10'd7);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (trig && !pt)     ev.push_back(evc(cyc - base, K_TR));
      if (!trig && pt)     ev.push_back(evc(cyc - base, K_TF));
      if (data_out && !pd) ev.push_back(evc(cyc - base, K_DR));
      if (!data_out && pd) ev.push_back(evc(cyc - base, K_DF));
      if (done)            ev.push_back(evc(cyc - base, K_DN));
      if (!busy && pb)     ev.push_back(evc(cyc - base, K_BF));
      if (cfg_err)         ev.push_back(evc(cyc - base, K_ER));
      pt = trig; pd = data_out; pb = busy;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({trig, data_out, busy, done, cfg_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want 00000", {trig, data_out, busy, done, cfg_err});
    end
    n_checks++;
    if (shot_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset shot_count: got %0d want 0", shot_count);
    end
  endtask

  task automatic test_idle_ring();
    int edges[$];
    int exp_e[$];
    int highs;
    exp_e = '{83, 247, 411};
    highs = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (dut.ring_edge) edges.push_back(cyc);
      if (trig || data_out || busy) highs++;
    end
    n_checks++;
    if (highs !== 0) begin
      n_fail++;
      $display("FAIL idle outputs: got %0d active cycles want 0", highs);
    end
    n_checks++;
    if (edges.size() !== exp_e.size()) begin
      n_fail++;
      $display("FAIL idle ring_edge count: got %0d want %0d", edges.size(), exp_e.size());
    end
    for (int i = 0; i < exp_e.size() && i < edges.size(); i++) begin
      n_checks++;
      if (edges[i] !== exp_e[i]) begin
        n_fail++;
        $display("FAIL idle ring_edge %0d: got cycle %0d want %0d", i, edges[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_cfg_err();
    logic want_err;
    for (int c = 0; c < 8; c++) begin
      set_cfg(1'b1, 8'd2, 21'd3, 8'd1, 8'd2, 8'd27, 10'd5);
      want_err = 1'b1;
      case (c)
        0: cfg_trig_len = 8'd0;
        1: cfg_trig_len = 8'd4;
        2: cfg_dout_delay = 8'd4;
        3: cfg_dout_offset = 8'd164;
        4: cfg_op_width = 10'd0;
        5: burst_len = 8'd0;
        6: begin cfg_dout_offset = 8'd163; cfg_trig_len = 8'd3; cfg_dout_delay = 8'd3; want_err = 1'b0; end
        default: begin mode = 1'b0; burst_len = 8'd0; want_err = 1'b0; end
      endcase
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++;
      if ({cfg_err, busy} !== {want_err, ~want_err}) begin
        n_fail++;
        $display("FAIL cfg_check case %0d: got cfg_err=%b busy=%b want cfg_err=%b busy=%b",
                 c, cfg_err, busy, want_err, ~want_err);
      end
      step();
      n_checks++;
      if ({cfg_err, trig, data_out} !== 3'b000) begin
        n_fail++;
        $display("FAIL cfg_check case %0d second cycle: got cfg_err/trig/data=%b want 000",
                 c, {cfg_err, trig, data_out});
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
    end
  endtask

  task automatic test_burst(input string name, input bit poke);
    int s, t0;
    int exp_ev[$];
    align0();
    set_cfg(1'b1, 8'd2, 21'd3, 8'd1, 8'd2, 8'd27, 10'd5);
    s = cyc; t0 = s + 84; base = t0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if ({busy, shot_count} !== {1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL %s accept: got busy=%b shot_count=%0d want busy=1 shot_count=0", name, busy, shot_count);
    end
    watch(t0 + 1400 - cyc, poke ? s + 500 : -1);
    exp_ev = '{evc(0, K_TR), evc(164, K_TF), evc(436, K_DR), evc(441, K_DF),
               evc(656, K_TR), evc(820, K_TF), evc(1092, K_DR), evc(1097, K_DF),
               evc(1313, K_DN), evc(1313, K_BF)};
    n_checks++;
    if (ev.size() !== exp_ev.size()) begin
      n_fail++;
      $display("FAIL %s event count: got %0d want %0d", name, ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < ev.size(); i++) begin
      n_checks++;
      if (ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL %s event %0d: got off=%0d kind=%0d want off=%0d kind=%0d",
                 name, i, ev[i] / 8, ev[i] % 8, exp_ev[i] / 8, exp_ev[i] % 8);
      end
    end
    n_checks++;
    if ({busy, shot_count} !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL %s end state: got busy=%b shot_count=%0d want busy=0 shot_count=2", name, busy, shot_count);
    end
  endtask

  task automatic test_continuous();
    int t0;
    int exp_ev[$];
    align0();
    set_cfg(1'b0, 8'd0, 21'd1, 8'd1, 8'd0, 8'd10, 10'd400);
    t0 = cyc + 84; base = t0;
    start = 1'b1;
    step();
    start = 1'b0;
    watch(t0 + 1100 - cyc, -1);
    exp_ev = '{evc(0, K_TR), evc(91, K_DR), evc(164, K_TF), evc(328, K_TR),
               evc(491, K_DF), evc(492, K_TF), evc(656, K_TR), evc(747, K_DR),
               evc(820, K_TF), evc(984, K_TR)};
    n_checks++;
    if (ev.size() !== exp_ev.size()) begin
      n_fail++;
      $display("FAIL continuous event count: got %0d want %0d", ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < ev.size(); i++) begin
      n_checks++;
      if (ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL continuous event %0d: got off=%0d kind=%0d want off=%0d kind=%0d",
                 i, ev[i] / 8, ev[i] % 8, exp_ev[i] / 8, exp_ev[i] % 8);
      end
    end
    n_checks++;
    if ({trig, data_out, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL continuous pre-abort: got trig/data/busy=%b want 111", {trig, data_out, busy});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({trig, data_out, busy, done, shot_count} !== {4'b0000, 8'd3}) begin
      n_fail++;
      $display("FAIL continuous abort: got trig/data/busy/done=%b shot_count=%0d want 0000 3",
               {trig, data_out, busy, done}, shot_count);
    end
  endtask

  task automatic test_abort_burst();
    int t0;
    int exp_ev[$];
    align0();
    set_cfg(1'b1, 8'd3, 21'd3, 8'd1, 8'd0, 8'd27, 10'd50);
    t0 = cyc + 84; base = t0;
    start = 1'b1;
    step();
    start = 1'b0;
    watch(t0 + 780 - cyc, -1);
    exp_ev = '{evc(0, K_TR), evc(108, K_DR), evc(158, K_DF), evc(164, K_TF),
               evc(656, K_TR), evc(764, K_DR)};
    n_checks++;
    if (ev.size() !== exp_ev.size()) begin
      n_fail++;
      $display("FAIL abort event count: got %0d want %0d", ev.size(), exp_ev.size());
    end
    for (int i = 0; i < exp_ev.size() && i < ev.size(); i++) begin
      n_checks++;
      if (ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL abort event %0d: got off=%0d kind=%0d want off=%0d kind=%0d",
                 i, ev[i] / 8, ev[i] % 8, exp_ev[i] / 8, exp_ev[i] % 8);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if ({trig, data_out, busy, done, shot_count} !== {4'b0000, 8'd1}) begin
      n_fail++;
      $display("FAIL abort outputs: got trig/data/busy/done=%b shot_count=%0d want 0000 1",
               {trig, data_out, busy, done}, shot_count);
    end
    watch(400, -1);
    n_checks++;
    if (ev.size() !== 0 || shot_count !== 8'd1) begin
      n_fail++;
      $display("FAIL abort quiet: got %0d events shot_count=%0d want 0 events shot_count=1", ev.size(), shot_count);
    end
  endtask

  task automatic test_async_reset();
    int s;
    align0();
    set_cfg(1'b0, 8'd0, 21'd1, 8'd1, 8'd0, 8'd10, 10'd400);
    s = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    watch(s + 180 - cyc, -1);
    n_checks++;
    if ({trig, data_out, busy} !== 3'b111) begin
      n_fail++;
      $display("FAIL async_reset pre: got trig/data/busy=%b want 111", {trig, data_out, busy});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({trig, data_out, busy, done, cfg_err, shot_count} !== 13'd0 || dut.ring_ph !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: got outputs=%b shot_count=%0d ring_ph=%0d want all 0",
               {trig, data_out, busy, done, cfg_err}, shot_count, dut.ring_ph);
    end
    #1 rst = 1'b0;
    watch(300, -1);
    n_checks++;
    if (ev.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset after release: got %0d events busy=%b want 0 events busy=0", ev.size(), busy);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    test_idle_ring();
    test_cfg_err();
    test_burst("burst", 1'b0);
    test_burst("start_while_busy", 1'b1);
    test_continuous();
    test_abort_burst();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
